wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  execute-stage result valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a result.
REQ-007 SHALL have port in_rd  input  ADDR_WIDTH  destination register index.
REQ-008 SHALL have port in_result  input  DATA_WIDTH  ALU result, or load byte address when in_is_load=1.
REQ-009 SHALL have port in_is_load  input  1  result is a load address.
REQ-010 SHALL have port in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 SHALL have port in_pc  input  DATA_WIDTH  PC of the instruction.
REQ-012 SHALL have port mem_req_valid  output  1  load request to data memory.
REQ-013 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-014 SHALL have port mem_req_addr  output  DATA_WIDTH  word-aligned address, low 2 bits 0.
REQ-015 SHALL have port mem_rsp_valid  input  1  read data returned, single-cycle pulse.
REQ-016 SHALL have port mem_rsp_data  input  DATA_WIDTH  full aligned word.
REQ-017 SHALL have port rf_wen  output  1  register-file write enable.
REQ-018 SHALL have port rf_waddr  output  ADDR_WIDTH  register-file write index.
REQ-019 SHALL have port rf_wdata  output  DATA_WIDTH  register-file write data.
REQ-020 SHALL have port retire_valid  output  1  one-cycle pulse per retired instruction.
REQ-021 SHALL have port retire_pc  output  DATA_WIDTH  PC of retired instruction.
REQ-022 SHALL have port load_err  output  1  sticky misaligned or illegal-funct3 load flag.

Function
REQ-023 SHALL implement FSM states IDLE, REQ, WAIT; accept occurs on in_valid && in_ready at a rising edge.
REQ-024 SHALL drive in_ready = 1 only in IDLE.
REQ-025 SHALL, on accepting a non-load in cycle N, assert rf_wen, rf_waddr=in_rd, rf_wdata=in_result, retire_valid, retire_pc=in_pc in cycle N+1, each for exactly one cycle, and stay in IDLE (back-to-back non-loads sustain one per cycle).
REQ-026 SHALL, on accepting a valid aligned load, latch rd/funct3/addr/pc and go IDLE->REQ.
REQ-027 SHALL in REQ hold mem_req_valid=1 and mem_req_addr={addr[31:2],2'b00} stable until mem_req_ready, then go to WAIT.
REQ-028 SHALL in WAIT, on mem_rsp_valid in cycle M, write the extended value in cycle M+1 with retire pulse and return to IDLE at the same edge.
REQ-029 SHALL select byte = data[8*addr[1:0]+7 -: 8], halfword = data[16*addr[1]+15 -: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-030 SHALL treat LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 in {011,110,111} as faulty: no memory request, no rf_wen, set load_err, still retire next cycle, stay IDLE.
REQ-031 SHALL suppress rf_wen (keep retire) when destination index is 0.
REQ-032 SHALL ignore mem_rsp_valid in IDLE and REQ.
REQ-033 SHALL hold rf_wen, retire_valid low in every cycle not covered by REQ-025/028/030.

Reset
REQ-034 SHALL, while rst_n=0, force state IDLE, rf_wen=0, rf_waddr=0, rf_wdata=0, retire_valid=0, retire_pc=0, mem_req_valid=0, mem_req_addr=0, load_err=0, immediately (asynchronously).
REQ-035 SHALL, on reset during REQ or WAIT, abandon the load; a response arriving after release SHALL be ignored.
REQ-036 SHALL clear load_err only by reset.

Verification
REQ-037 Non-load rd=5 result=0x1234 pc=0x80000000 at cycle N -> cycle N+1 rf_wen=1 waddr=5 wdata=0x1234, retire_pc=0x80000000.
REQ-038 LB rd=3 addr=0x80000103, mem_req_ready after 2 cycles, data 0x80FF_0000 -> mem_req_addr=0x80000100, wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LH addr=0x80000002 data 0x8001_1234 -> wdata=0xFFFF8001; LHU -> 0x00008001; LW addr=0x80000000 -> 0x80011234.
REQ-040 LW addr=0x80000002 -> no mem_req_valid, rf_wen=0, retire_valid=1 next cycle, load_err=1 stays set.
REQ-041 Non-load rd=0 -> rf_wen=0, retire_valid=1; in_valid during WAIT -> in_ready=0, not accepted.
REQ-042 rst_n low in WAIT, response pulsed after release -> outputs zero, no rf_wen, in_ready=1.

Source files
------------

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - writeback unit: retires ALU results, performs aligned loads with extension
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               execute-stage result handshake (ready only in IDLE)
//   in_rd, in_result, in_is_load,   destination, result or load byte address,
//   in_funct3, in_pc                load type, instruction PC
//   mem_req_valid/ready, mem_req_addr   word-aligned load request
//   mem_rsp_valid, mem_rsp_data     single-cycle read-data return
//   rf_wen, rf_waddr, rf_wdata      register-file write port
//   retire_valid, retire_pc         one pulse per retired instruction
//   load_err                        sticky misaligned / illegal-funct3 load flag
module wb_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  retire_valid,
  output logic [DATA_WIDTH-1:0] retire_pc,
  output logic                  load_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] pc_q;

  logic                  accept;
  logic                  load_fault;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_value;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Misaligned halfword/word or a funct3 with no defined load type.
  always_comb begin
    load_fault = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: load_fault = 1'b0;
      3'b001, 3'b101: load_fault = in_result[0];
      3'b010:         load_fault = |in_result[1:0];
      default:        load_fault = 1'b1;
    endcase
  end

  // Lane selection uses the byte offset latched at accept, not the live input.
  always_comb begin
    ld_byte = 8'h00;
    case (off_q)
      2'd0: ld_byte = mem_rsp_data[7:0];
      2'd1: ld_byte = mem_rsp_data[15:8];
      2'd2: ld_byte = mem_rsp_data[23:16];
      2'd3: ld_byte = mem_rsp_data[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = off_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (f3_q)
      3'b000:  ld_value = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_value = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_value = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_value = mem_rsp_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_q          <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      pc_q          <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      rf_wen        <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      retire_valid  <= 1'b0;
      retire_pc     <= '0;
      load_err      <= 1'b0;
    end else begin
      // Write and retire are pulses; only the branches below raise them.
      rf_wen       <= 1'b0;
      retire_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!in_is_load) begin
              rf_wen       <= (in_rd != '0);
              rf_waddr     <= in_rd;
              rf_wdata     <= in_result;
              retire_valid <= 1'b1;
              retire_pc    <= in_pc;
            end else if (load_fault) begin
              // Faulty load retires without touching memory or the register file.
              load_err     <= 1'b1;
              rf_waddr     <= in_rd;
              retire_valid <= 1'b1;
              retire_pc    <= in_pc;
            end else begin
              rd_q          <= in_rd;
              f3_q          <= in_funct3;
              off_q         <= in_result[1:0];
              pc_q          <= in_pc;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_result[DATA_WIDTH-1:2], 2'b00};
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rf_wen       <= (rd_q != '0);
            rf_waddr     <= rd_q;
            rf_wdata     <= ld_value;
            retire_valid <= 1'b1;
            retire_pc    <= pc_q;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - scoreboard bench for wb_unit
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_result = '0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        load_err;

  wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_pc(in_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Retire monitor: every retire pops one expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (retire_valid) begin
        if (sb.size() == 0) begin
          chk("retire_unexpected", retire_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rf_wen", rf_wen, e.wen);
          if (e.wen) begin
            chk("rf_waddr", rf_waddr, e.rd);
            chk("rf_wdata", rf_wdata, e.data);
          end
          chk("retire_pc", retire_pc, e.pc);
        end
      end else if (rf_wen) begin
        chk("wen_without_retire", retire_valid, 1);
      end
    end
  end

  task automatic send_alu(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
    @(negedge clk);
    chk("alu_in_ready", in_ready, 1);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_result = res; in_pc = pc; in_funct3 = 3'b000;
    sb.push_back('{(rd != 0), rd, res, pc});
    @(negedge clk);
    in_valid = 1'b0;
    chk("alu_latency", retire_valid, 1);
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] data, input logic [31:0] exp_data,
                         input bit faulty, input int ready_delay, input bit do_reset);
    @(negedge clk);
    // Stray response while idle must be ignored.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_result = addr; in_funct3 = f3; in_pc = pc;
    if (!do_reset) sb.push_back('{(!faulty && rd != 0), rd, exp_data, pc});
    @(negedge clk);
    in_valid = 1'b0;
    if (faulty) begin
      chk("fault_retire", retire_valid, 1);
      chk("fault_no_req", mem_req_valid, 0);
      chk("fault_load_err", load_err, 1);
      chk("fault_in_ready", in_ready, 1);
      return;
    end
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, {addr[31:2], 2'b00});
    chk("req_in_ready", in_ready, 0);
    for (int i = 0; i < ready_delay; i++) begin
      if (i == 0) begin mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD; end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("req_hold", mem_req_valid, 1);
      chk("req_addr_stable", mem_req_addr, {addr[31:2], 2'b00});
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("req_drop", mem_req_valid, 0);
    // In WAIT: a new result must not be accepted.
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd7; in_result = 32'h7777; in_pc = 32'h7000;
    chk("wait_in_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    if (do_reset) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rf_wen", rf_wen, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_retire_pc", retire_pc, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_load_err", load_err, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_data = data;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("post_rst_no_wen", rf_wen, 0);
      chk("post_rst_no_retire", retire_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
      return;
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = data;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("load_retire", retire_valid, 1);
    chk("load_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_retire", retire_valid, 0);
    chk("reset_req_valid", mem_req_valid, 0);
    chk("reset_load_err", load_err, 0);
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    send_alu(5'd5, 32'h1234, 32'h8000_0000);

    // Back-to-back non-loads, one retire per cycle, rd=0 in the middle.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [4:0]  rd;
      logic [31:0] res;
      rd  = (i == 2) ? 5'd0 : 5'(i + 8);
      res = $urandom;
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_result = res; in_pc = 32'h100 + 32'(4 * i);
      sb.push_back('{(rd != 0), rd, res, 32'h100 + 32'(4 * i)});
      @(negedge clk);
      chk("b2b_retire", retire_valid, 1);
    end
    in_valid = 1'b0;

    do_load(5'd3, 32'h8000_0103, 3'b000, 32'h200, 32'h80FF_0000, 32'hFFFF_FF80, 0, 2, 0);
    do_load(5'd3, 32'h8000_0103, 3'b100, 32'h204, 32'h80FF_0000, 32'h0000_0080, 0, 2, 0);
    do_load(5'd4, 32'h8000_0002, 3'b001, 32'h208, 32'h8001_1234, 32'hFFFF_8001, 0, 0, 0);
    do_load(5'd4, 32'h8000_0002, 3'b101, 32'h20C, 32'h8001_1234, 32'h0000_8001, 0, 1, 0);
    do_load(5'd6, 32'h8000_0000, 3'b010, 32'h210, 32'h8001_1234, 32'h8001_1234, 0, 3, 0);
    do_load(5'd0, 32'h8000_0001, 3'b000, 32'h214, 32'h0000_5600, 32'h0000_0056, 0, 1, 0);

    chk("load_err_before_fault", load_err, 0);
    do_load(5'd9, 32'h8000_0002, 3'b010, 32'h300, 32'h0, 32'h0, 1, 0, 0);
    do_load(5'd9, 32'h8000_0000, 3'b011, 32'h304, 32'h0, 32'h0, 1, 0, 0);
    do_load(5'd9, 32'h8000_0001, 3'b101, 32'h308, 32'h0, 32'h0, 1, 0, 0);
    send_alu(5'd1, 32'hCAFE_F00D, 32'h30C);
    chk("load_err_sticky", load_err, 1);

    do_load(5'd10, 32'h8000_0004, 3'b010, 32'h400, 32'h1357_9BDF, 32'h1357_9BDF, 0, 1, 1);

    send_alu(5'd2, 32'h0000_00AA, 32'h500);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
